match_timer: RTL
================

MATCH_TIMER -- requirements
Module: match_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per one-second tick; minimum 2.
REQ-002 SHALL have parameter INIT_MIN, default 2: BCD-valid minutes preset, 0..99.
REQ-003 SHALL have parameter INIT_SEC, default 0: BCD-valid seconds preset, 0..59.
REQ-004 SHALL have parameter WARN_SEC, default 10: remaining-time warning threshold in seconds.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins counting.
REQ-008 SHALL have port pause_tgl, input, 1 bit: one-cycle pulse that toggles RUN and PAUSE.
REQ-009 SHALL have port load, input, 1 bit: one-cycle pulse that loads load_min/load_sec as the preset and returns to IDLE.
REQ-010 SHALL have port load_min, input, 8 bits: two BCD digits of minutes.
REQ-011 SHALL have port load_sec, input, 8 bits: two BCD digits of seconds.
REQ-012 SHALL have port mode, input, 1 bit: 0 counts down to 00:00; 1 counts up from 00:00 to the preset; sampled only on start.
REQ-013 SHALL have outputs min1, min2, sec1, sec2, each 4 bits: BCD digits (tens, ones) of the displayed time.
REQ-014 SHALL have output running, 1 bit: high in RUN.
REQ-015 SHALL have output expired, 1 bit: high in DONE.
REQ-016 SHALL have output done_pulse, 1 bit: one cycle on entry to DONE.
REQ-017 SHALL have output tick, 1 bit: one-cycle pulse on each counted second.
REQ-018 SHALL have output warn, 1 bit: high in RUN while remaining seconds are at or below WARN_SEC.
REQ-019 SHALL have output load_err, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
- IDLE -start-> RUN
- RUN -pause_tgl-> PAUSE
- PAUSE -pause_tgl-> RUN
- RUN -terminal tick-> DONE
- any state -load-> IDLE
- DONE -start-> RUN, after reinitialising from the preset
REQ-021 SHALL apply input priority load > start > pause_tgl when inputs coincide in one cycle.
- start is ignored in RUN and PAUSE.
- pause_tgl is ignored in IDLE and DONE.
REQ-022 SHALL hold a prescaler counting 0..TICK_DIV-1 only in RUN.
- Frozen in PAUSE, so resume continues the partial second.
- Cleared to 0 on start and load.
REQ-023 SHALL assert tick, and update digits, on the cycle after the prescaler reaches TICK_DIV-1, i.e. TICK_DIV cycles after start.
REQ-024 SHALL, in down mode, decrement BCD per tick.
- sec2 9->0 per tick.
- sec2 wraps 0->9 with sec1 decrement; sec1 wraps 0->5 with minute decrement.
- min2 wraps 0->9 with min1 decrement.
REQ-025 SHALL, in up mode, increment the mirror image of REQ-024: sec2 9->0 carry, sec1 5->0 carry, min2 9->0 carry into min1.
REQ-026 SHALL enter DONE, with done_pulse, on the tick whose result equals 00:00 (down) or the preset (up); the digits then hold.
REQ-027 SHALL, on start, load digits with the preset (down mode) or 00:00 (up mode).
- A zero preset enters DONE on the first tick.
REQ-028 SHALL reject a load with any BCD digit above 9 or seconds tens above 5.
- A rejected load pulses load_err and leaves the preset, state and digits unchanged.
- A valid load sets the preset and shows it on the digits (down mode) or 00:00 (up mode).
REQ-029 SHALL compute warn from remaining seconds: preset minus elapsed in up mode; min*60+sec in down mode. Binary width is 13 bits.

Reset
REQ-030 SHALL, on rst low, asynchronously set the following; release is synchronous to clk:
- state IDLE, prescaler 0, preset INIT_MIN:INIT_SEC, mode latch 0
- digits show the preset
- running, expired, done_pulse, tick, warn, load_err all 0
REQ-031 SHALL discard an in-flight count on reset mid-operation, with no done_pulse.

Structure
REQ-032 SHALL place the FSM state encoding, BCD digit limits (9, 5) and the remaining-seconds width in shared package timer_pkg.
REQ-033 SHALL isolate the prescaler in sub-module tick_prescaler, with ports clk, rst, en, clr, tick and parameter TICK_DIV.

Verification
REQ-034 SHALL verify, with TICK_DIV=4, preset 00:12, mode 0, start: tick every 4 cycles, then 00:11 ... 00:10 (warn high) ... 00:00, with done_pulse once and expired high.
REQ-035 SHALL verify down-mode borrow: load 10:00, start, one tick -> 09:59; load 01:00 -> 00:59.
REQ-036 SHALL verify up-mode: load 01:05, mode 1, start -> 00:00; after 60 ticks 01:00; after 65 ticks DONE, showing 01:05.
REQ-037 SHALL verify pause: pause_tgl at prescaler 2 -> digits and prescaler frozen for 20 cycles; pause_tgl -> next tick 2 cycles later.
REQ-038 SHALL verify simultaneous load 00:30 and start in RUN: IDLE showing 00:30, with no tick. Load 00:6A -> load_err pulse, preset unchanged.
REQ-039 SHALL verify reset: rst low mid-RUN at 00:05 -> immediate 02:00 IDLE, all flags 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the match timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         REM_W        = 13;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] s1;
    logic [3:0] s2;
  } bcd_time_t;

  function automatic logic bcd_ok(logic [7:0] m, logic [7:0] s);
    return (m[7:4] <= BCD_MAX) && (m[3:0] <= BCD_MAX) &&
           (s[7:4] <= SEC_TENS_MAX) && (s[3:0] <= BCD_MAX);
  endfunction

  function automatic logic [REM_W-1:0] to_secs(bcd_time_t t);
    logic [REM_W-1:0] r;
    r = {9'd0, t.m1} * REM_W'(600) + {9'd0, t.m2} * REM_W'(60) +
        {9'd0, t.s1} * REM_W'(10)  + {9'd0, t.s2};
    return r;
  endfunction

  function automatic bcd_time_t bcd_dec(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s2 != 4'd0) r.s2 = t.s2 - 4'd1;
    else begin
      r.s2 = BCD_MAX;
      if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = SEC_TENS_MAX;
        if (t.m2 != 4'd0) r.m2 = t.m2 - 4'd1;
        else begin
          r.m2 = BCD_MAX;
          r.m1 = (t.m1 == 4'd0) ? BCD_MAX : t.m1 - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_time_t bcd_inc(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s2 != BCD_MAX) r.s2 = t.s2 + 4'd1;
    else begin
      r.s2 = 4'd0;
      if (t.s1 != SEC_TENS_MAX) r.s1 = t.s1 + 4'd1;
      else begin
        r.s1 = 4'd0;
        if (t.m2 != BCD_MAX) r.m2 = t.m2 + 4'd1;
        else begin
          r.m2 = 4'd0;
          r.m1 = (t.m1 == BCD_MAX) ? 4'd0 : t.m1 + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second terminal-count strobe; holds its count while disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the owner can update its digits on the same edge the count wraps.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/match_timer.sv
// MM:SS match timer: BCD countdown/count-up with pause, preset load and warning flag.
module match_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int INIT_MIN = 2,
  parameter int INIT_SEC = 0,
  parameter int WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_tgl,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       mode,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       tick,
  output logic       warn,
  output logic       load_err
);

  localparam bcd_time_t INIT_T = '{m1: 4'(INIT_MIN / 10), m2: 4'(INIT_MIN % 10),
                                   s1: 4'(INIT_SEC / 10), s2: 4'(INIT_SEC % 10)};

  state_t           state, state_nx;
  bcd_time_t        cur, cur_nx, preset, preset_nx, nxt, target;
  logic             mode_q, mode_nx;
  logic             load_valid, load_ok, start_ok, pause_ok;
  logic             pre_en, pre_clr, pre_tick, at_target, hit;
  logic             tick_q, done_q, err_q;
  logic [REM_W-1:0] rem;

  assign load_valid = bcd_ok(load_min, load_sec);
  assign load_ok    = load && load_valid;
  // A rejected load is a no-op apart from load_err, so it does not mask start/pause.
  assign start_ok   = !load_ok && start && (state == IDLE || state == DONE);
  assign pause_ok   = !load_ok && pause_tgl && (state == RUN || state == PAUSE);

  assign pre_en  = (state == RUN) && !load_ok && !pause_ok;
  assign pre_clr = load_ok || start_ok;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (pre_tick)
  );

  assign target = mode_q ? preset : '0;
  assign nxt    = mode_q ? bcd_inc(cur) : bcd_dec(cur);
  // at_target covers a zero-length run (zero preset): finish without stepping past it.
  assign at_target = (cur == target);
  assign hit       = at_target || (nxt == target);

  always_comb begin
    state_nx  = state;
    cur_nx    = cur;
    preset_nx = preset;
    mode_nx   = mode_q;
    if (load_ok) begin
      preset_nx = {load_min, load_sec};
      state_nx  = IDLE;
      cur_nx    = mode_q ? '0 : {load_min, load_sec};
    end else if (start_ok) begin
      state_nx = RUN;
      mode_nx  = mode;
      cur_nx   = mode ? '0 : preset;
    end else if (pause_ok) begin
      state_nx = (state == RUN) ? PAUSE : RUN;
    end else if (pre_tick) begin
      cur_nx = at_target ? cur : nxt;
      if (hit) state_nx = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cur    <= INIT_T;
      preset <= INIT_T;
      mode_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cur    <= cur_nx;
      preset <= preset_nx;
      mode_q <= mode_nx;
      tick_q <= pre_tick;
      done_q <= pre_tick && hit;
      err_q  <= load && !load_valid;
    end
  end

  assign rem = mode_q ? (to_secs(preset) - to_secs(cur)) : to_secs(cur);

  assign {min1, min2, sec1, sec2} = cur;
  assign running    = (state == RUN);
  assign expired    = (state == DONE);
  assign warn       = running && (rem <= REM_W'(WARN_SEC));
  assign tick       = tick_q;
  assign done_pulse = done_q;
  assign load_err   = err_q;

endmodule
